// File: rtl/seq_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : seq_pp_accumulator
// Description : Sequential shift-and-add multiplier front end. It produces a
//               carry-save (carry row, sum row) pair for a final adder.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pp_accumulator #(
    parameter int OPWIDTH        = 8,
    parameter int INPUTWIDTH     = 16,
    parameter int LEASTSIGNIFCOL = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [OPWIDTH-1:0]                   a,
    input  logic [OPWIDTH-1:0]                   b,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [INPUTWIDTH-1:LEASTSIGNIFCOL]   pp_accum [1:0]
);

    localparam int                    c_CNT_W = (OPWIDTH > 1) ? $clog2(OPWIDTH) : 1;
    localparam logic [c_CNT_W-1:0]    c_LAST  = c_CNT_W'(OPWIDTH - 1);
    localparam logic [INPUTWIDTH-1:0] c_KEEP  = {INPUTWIDTH{1'b1}} << LEASTSIGNIFCOL;

    if (INPUTWIDTH != 2 * OPWIDTH) begin : g_width_check
        $error("seq_pp_accumulator: INPUTWIDTH must equal 2*OPWIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OPWIDTH-1:0]    r_a;
    logic [OPWIDTH-1:0]    r_b;
    logic [c_CNT_W-1:0]    r_i;
    logic [INPUTWIDTH-1:0] r_sum;
    logic [INPUTWIDTH-1:0] r_carry;

    logic [INPUTWIDTH-1:0] w_pp;
    logic [INPUTWIDTH-1:0] w_maj;
    logic [INPUTWIDTH-1:0] w_sum_nxt;
    logic [INPUTWIDTH-1:0] w_carry_nxt;
    logic                  w_last;

    // Discarded columns are masked on every term so they never re-enter via carries.
    assign w_pp        = r_b[r_i] ? ((INPUTWIDTH'(r_a) << r_i) & c_KEEP) : '0;
    assign w_sum_nxt   = r_sum ^ r_carry ^ w_pp;
    assign w_maj       = (r_sum & r_carry) | (r_sum & w_pp) | (r_carry & w_pp);
    assign w_carry_nxt = (w_maj << 1) & c_KEEP;
    assign w_last      = (r_i == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_sum   <= '0;
            r_carry <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_i     <= '0;
                        r_sum   <= '0;
                        r_carry <= '0;
                    end
                end
                S_ACCUM: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_carry_nxt;
                    // Counter saturates on the last step instead of wrapping.
                    if (!w_last) begin
                        r_i <= r_i + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pp_accum[1] = r_carry[INPUTWIDTH-1:LEASTSIGNIFCOL];
    assign pp_accum[0] = r_sum[INPUTWIDTH-1:LEASTSIGNIFCOL];

endmodule
`default_nettype wire

// File: tb/tb_seq_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pp_accumulator
// Description : Scoreboard bench for seq_pp_accumulator (full and truncated).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pp_accumulator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pp_accum [1:0];

    logic        t_in_valid;
    logic        t_in_ready;
    logic [7:0]  t_a;
    logic [7:0]  t_b;
    logic        t_out_valid;
    logic        t_out_ready;
    logic [15:4] t_pp [1:0];

    seq_pp_accumulator #(.OPWIDTH(8), .INPUTWIDTH(16), .LEASTSIGNIFCOL(0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp_accum  (pp_accum)
    );

    seq_pp_accumulator #(.OPWIDTH(8), .INPUTWIDTH(16), .LEASTSIGNIFCOL(4)) u_dut_trunc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (t_in_valid),
        .in_ready  (t_in_ready),
        .a         (t_a),
        .b         (t_b),
        .out_valid (t_out_valid),
        .out_ready (t_out_ready),
        .pp_accum  (t_pp)
    );

    typedef struct {
        logic [15:0] prod;
        bit          zero;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec    = 0;
    int   n_fail   = 0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per accepted result.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] s;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                s = pp_accum[1] + pp_accum[0];
                check("product", s, e.prod);
                check("in_ready_in_done", in_ready, 1'b0);
                if (e.zero) begin
                    check("carry_row_zero", pp_accum[1], 16'h0);
                    check("sum_row_zero", pp_accum[0], 16'h0);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] prod, input bit zero, input bit push);
        int guard = 0;
        @(posedge clk); #1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        if (push) exp_q.push_back('{prod, zero});
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || !in_ready) && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_pending", exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] cap_c;
        logic [15:0] cap_s;
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          g;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        out_ready   = 1'b1;
        t_in_valid  = 1'b0;
        t_a         = '0;
        t_b         = '0;
        t_out_ready = 1'b1;

        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_carry_row", pp_accum[1], 16'h0);
        check("rst_sum_row", pp_accum[0], 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-scale operands with exact latency.
        @(posedge clk); #1;
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
        exp_q.push_back('{16'hFE01, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'h00; b = 8'h00;
        repeat (7) @(posedge clk);
        #1;
        check("latency_before_e8", out_valid, 1'b0);
        @(posedge clk); #1;
        check("latency_at_e8", out_valid, 1'b1);
        drain();

        // Truncated instance: columns below 4 dropped.
        @(posedge clk); #1;
        t_in_valid = 1'b1; t_a = 8'h0F; t_b = 8'h0F;
        @(posedge clk); #1;
        t_in_valid = 1'b0; t_a = 8'hFF; t_b = 8'hFF;
        g = 0;
        while (!t_out_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("trunc_out_valid", t_out_valid, 1'b1);
        check("trunc_rows", {t_pp[1] + t_pp[0], 4'h0}, 16'h00B0);

        // Zero operands and directed products, back to back.
        send(8'hA5, 8'h00, 16'h0000, 1'b1, 1'b1);
        send(8'h00, 8'h5A, 16'h0000, 1'b1, 1'b1);
        send(8'h03, 8'h05, 16'h000F, 1'b0, 1'b1);
        send(8'h01, 8'h01, 16'h0001, 1'b0, 1'b1);
        send(8'h80, 8'h80, 16'h4000, 1'b0, 1'b1);
        send(8'hFF, 8'h01, 16'h00FF, 1'b0, 1'b1);
        send(8'h01, 8'hFF, 16'h00FF, 1'b0, 1'b1);
        send(8'hAA, 8'h55, 16'h3872, 1'b0, 1'b1);
        drain();

        // Backpressure with in_valid pulsing in DONE.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 16'h03A8, 1'b0, 1'b1);
        g = 0;
        while (!out_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("bp_out_valid", out_valid, 1'b1);
        cap_c = pp_accum[1];
        cap_s = pp_accum[0];
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk); #1;
            check("bp_carry_stable", pp_accum[1], cap_c);
            check("bp_sum_stable", pp_accum[0], cap_s);
            check("bp_in_ready_low", in_ready, 1'b0);
            check("bp_out_valid_held", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_release_out_valid", out_valid, 1'b0);
        check("bp_release_in_ready", in_ready, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("bp_no_capture", in_ready, 1'b1);

        // Reset in the middle of an operation.
        send(8'h77, 8'h99, 16'h0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_carry_row", pp_accum[1], 16'h0);
        check("midrst_sum_row", pp_accum[0], 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h03, 8'h05, 16'h000F, 1'b0, 1'b1);
        drain();

        // Random pairs with random downstream backpressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 200; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(ra, rb, 16'(ra) * 16'(rb), 1'b0, 1'b1);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
